// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the register-mapped I2C peripheral:
//   - I2C_BYTE_W      : width of one I2C data byte
//   - reg_ptr_t       : register-pointer type at the default register count
//   - ctrl_state_t    : controller FSM encoding (IDLE / ADDR / DATA)
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam int I2C_BYTE_W       = 8;
    localparam int DEFAULT_NUM_REGS = 16;
    localparam int DEFAULT_ADDR_W   = 4;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_ptr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/i2c_reg_file.sv
// ---------------------------------------------------------------------------
// i2c_reg_file
// NUM_REGS x 8-bit register file shared by the local host and the I2C side.
// Two write ports; the host port wins when both hit the same register in the
// same cycle. Two combinational read ports (host address and I2C pointer).
//
// Ports
//   clk, rst          clock, asynchronous active-low reset (all regs -> 0)
//   host_wr_en        host write strobe
//   host_addr         host register address (write and read)
//   host_wr_data      host write data
//   host_rd_data      regs[host_addr]
//   i2c_wr_en         I2C write strobe
//   i2c_addr          I2C register pointer (write and read)
//   i2c_wr_data       I2C write data
//   i2c_rd_data       regs[i2c_addr]
//   regs_flat         all registers, reg i at bits [8i+7:8i]
// ---------------------------------------------------------------------------
module i2c_reg_file
    import i2c_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           host_wr_en,
    input  logic [ADDR_W-1:0]              host_addr,
    input  logic [I2C_BYTE_W-1:0]          host_wr_data,
    output logic [I2C_BYTE_W-1:0]          host_rd_data,
    input  logic                           i2c_wr_en,
    input  logic [ADDR_W-1:0]              i2c_addr,
    input  logic [I2C_BYTE_W-1:0]          i2c_wr_data,
    output logic [I2C_BYTE_W-1:0]          i2c_rd_data,
    output logic [I2C_BYTE_W*NUM_REGS-1:0] regs_flat
);

    logic [I2C_BYTE_W-1:0] regs [NUM_REGS];
    logic                  i2c_blocked;

    // The I2C byte is dropped when the host writes the same register at once
    assign i2c_blocked = host_wr_en && (host_addr == i2c_addr);

    // Register storage: both ports may write different registers in one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (i2c_wr_en && !i2c_blocked) begin
                regs[i2c_addr] <= i2c_wr_data;
            end
            if (host_wr_en) begin
                regs[host_addr] <= host_wr_data;
            end
        end
    end

    assign host_rd_data = regs[host_addr];
    assign i2c_rd_data  = regs[i2c_addr];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[I2C_BYTE_W*g +: I2C_BYTE_W] = regs[g];
    end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_reg_ctrl
// Turns the byte interface of i2c_slave into a register-mapped peripheral.
// The first byte written in a transaction sets the register pointer, later
// written bytes store into registers, and transmit bytes are preloaded from
// the register at the pointer. The pointer advances after every data byte
// and wraps modulo NUM_REGS. A host port gives the fabric the same registers.
//
// Optional feature macro: I2C_REG_IRQ_EN
//   When defined, i2c_wr_strobe pulses bit [ptr] for one cycle after each
//   committed I2C register write (none for host-collided writes).
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   slave_selected    i2c_slave: address matched, transaction open
//   slave_rd_data     i2c_slave: byte received from the master
//   slave_rd_valid    i2c_slave: 1-cycle strobe, slave_rd_data valid
//   slave_io_busy     i2c_slave: byte shift in progress
//   slave_wr_data     to i2c_slave: next byte to transmit
//   slave_wr_en       to i2c_slave: 1-cycle load strobe for slave_wr_data
//   host_addr         host register address
//   host_wr_en        host write strobe
//   host_wr_data      host write data
//   host_rd_data      reg[host_addr], combinational
//   regs_flat         all registers, reg i at bits [8i+7:8i]
//   i2c_wr_strobe     (I2C_REG_IRQ_EN) per-register I2C write pulse
// ---------------------------------------------------------------------------
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           slave_selected,
    input  logic [I2C_BYTE_W-1:0]          slave_rd_data,
    input  logic                           slave_rd_valid,
    input  logic                           slave_io_busy,
    output logic [I2C_BYTE_W-1:0]          slave_wr_data,
    output logic                           slave_wr_en,
    input  logic [ADDR_W-1:0]              host_addr,
    input  logic                           host_wr_en,
    input  logic [I2C_BYTE_W-1:0]          host_wr_data,
    output logic [I2C_BYTE_W-1:0]          host_rd_data,
    output logic [I2C_BYTE_W*NUM_REGS-1:0] regs_flat
`ifdef I2C_REG_IRQ_EN
    ,
    output logic [NUM_REGS-1:0]            i2c_wr_strobe
`endif
);

    ctrl_state_t           state, next_state;
    logic [ADDR_W-1:0]     ptr, ptr_next;
    logic [I2C_BYTE_W-1:0] ptr_rd_data;

    logic sel_q, busy_q, rx_seen;
    logic sel_rise, sel_fall, busy_rise, busy_fall, tx_done;
    logic i2c_we;
    logic preload_now, pend_set, preload_pend, pend_next, preload_fire;

    i2c_reg_file #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_reg_file (
        .clk          (clk),
        .rst          (rst),
        .host_wr_en   (host_wr_en),
        .host_addr    (host_addr),
        .host_wr_data (host_wr_data),
        .host_rd_data (host_rd_data),
        .i2c_wr_en    (i2c_we),
        .i2c_addr     (ptr),
        .i2c_wr_data  (slave_rd_data),
        .i2c_rd_data  (ptr_rd_data),
        .regs_flat    (regs_flat)
    );

    assign sel_rise  =  slave_selected & ~sel_q;
    assign sel_fall  = ~slave_selected &  sel_q;
    assign busy_rise =  slave_io_busy  & ~busy_q;
    assign busy_fall = ~slave_io_busy  &  busy_q;

    // A byte shift that ends without any received byte was a transmit byte
    assign tx_done = busy_fall & ~rx_seen & ~slave_rd_valid;

    // Edge-detect history and the "byte received during this shift" flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            rx_seen <= 1'b0;
        end else begin
            sel_q  <= slave_selected;
            busy_q <= slave_io_busy;
            if (busy_rise) begin
                rx_seen <= slave_rd_valid;
            end else if (slave_rd_valid) begin
                rx_seen <= 1'b1;
            end
        end
    end

    // FSM state and register pointer; the pointer survives deselection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= ptr_next;
        end
    end

    // Next state, pointer update, I2C write and preload requests.
    // preload_now loads reg[ptr] in this cycle (pointer unchanged); pend_set
    // asks for a load once the new pointer value has been registered.
    // A deselect always wins last, so a byte arriving with it is still used.
    always_comb begin
        next_state  = state;
        ptr_next    = ptr;
        i2c_we      = 1'b0;
        preload_now = 1'b0;
        pend_set    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_rise) begin
                    next_state  = ADDR;
                    preload_now = 1'b1;
                end
            end
            ADDR: begin
                if (slave_rd_valid) begin
                    ptr_next   = slave_rd_data[ADDR_W-1:0];
                    next_state = DATA;
                    pend_set   = 1'b1;
                end else if (tx_done) begin
                    ptr_next   = ptr + ADDR_W'(1);
                    next_state = DATA;
                    pend_set   = 1'b1;
                end
            end
            DATA: begin
                if (slave_rd_valid) begin
                    i2c_we   = 1'b1;
                    ptr_next = ptr + ADDR_W'(1);
                end else if (tx_done) begin
                    ptr_next = ptr + ADDR_W'(1);
                    pend_set = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (sel_fall) begin
            next_state = IDLE;
        end
    end

    // Preloads wait while a byte is shifting and never fire back-to-back
    assign preload_fire = (preload_now | preload_pend) & ~slave_io_busy
                        & ~slave_wr_en & ~sel_fall;
    assign pend_next    = ~sel_fall
                        & (pend_set | ((preload_now | preload_pend) & ~preload_fire));

    // Transmit byte load towards i2c_slave
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            preload_pend  <= 1'b0;
            slave_wr_en   <= 1'b0;
            slave_wr_data <= '0;
        end else begin
            preload_pend <= pend_next;
            slave_wr_en  <= preload_fire;
            if (preload_fire) begin
                slave_wr_data <= ptr_rd_data;
            end
        end
    end

`ifdef I2C_REG_IRQ_EN
    logic i2c_commit;

    // Only writes that actually land in the register file raise a strobe
    assign i2c_commit = i2c_we & ~(host_wr_en && (host_addr == ptr));

    // One-cycle per-register notification of an I2C write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i2c_wr_strobe <= '0;
        end else if (i2c_commit) begin
            i2c_wr_strobe <= NUM_REGS'(1) << ptr;
        end else begin
            i2c_wr_strobe <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2c_reg_ctrl
// Self-checking bench for i2c_reg_ctrl at the default 16-register size.
// Expected transmit bytes are queued as stimulus is driven and popped when
// slave_wr_en pulses. Register contents are checked against a table and a
// shadow model. Build with I2C_REG_IRQ_EN defined to cover i2c_wr_strobe.
// ---------------------------------------------------------------------------
module tb_i2c_reg_ctrl;
    import i2c_pkg::*;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   slave_selected = 1'b0;
    logic [7:0]             slave_rd_data = 8'h00;
    logic                   slave_rd_valid = 1'b0;
    logic                   slave_io_busy = 1'b0;
    logic [7:0]             slave_wr_data;
    logic                   slave_wr_en;
    logic [ADDR_W-1:0]      host_addr = '0;
    logic                   host_wr_en = 1'b0;
    logic [7:0]             host_wr_data = 8'h00;
    logic [7:0]             host_rd_data;
    logic [8*NUM_REGS-1:0]  regs_flat;
`ifdef I2C_REG_IRQ_EN
    logic [NUM_REGS-1:0]    i2c_wr_strobe;
`endif

    always #5 clk = ~clk;

    i2c_reg_ctrl #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .slave_selected (slave_selected),
        .slave_rd_data  (slave_rd_data),
        .slave_rd_valid (slave_rd_valid),
        .slave_io_busy  (slave_io_busy),
        .slave_wr_data  (slave_wr_data),
        .slave_wr_en    (slave_wr_en),
        .host_addr      (host_addr),
        .host_wr_en     (host_wr_en),
        .host_wr_data   (host_wr_data),
        .host_rd_data   (host_rd_data),
        .regs_flat      (regs_flat)
`ifdef I2C_REG_IRQ_EN
        ,
        .i2c_wr_strobe  (i2c_wr_strobe)
`endif
    );

    typedef struct {
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } host_vec_t;

    int         checks_total  = 0;
    int         checks_passed = 0;
    logic [7:0] exp_q [$];
    logic [7:0] m_regs [NUM_REGS];
    reg_ptr_t   m_ptr = '0;
    logic       m_in_addr = 1'b0;
    logic       prev_wr_en = 1'b0;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every transmit load must match the oldest queued byte
    always @(negedge clk) begin
        if (rst && slave_wr_en) begin
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("[TB] FAIL unexpected_preload: got %0h, expected no load", slave_wr_data);
            end else begin
                checkOutput("preload_data", slave_wr_data, exp_q.pop_front());
            end
            checkOutput("wr_en_single_cycle", prev_wr_en, 1'b0);
        end
        prev_wr_en = rst && slave_wr_en;
    end

    task automatic readReg(input logic [3:0] a, output logic [7:0] d);
        host_addr = a;
        #1;
        d = host_rd_data;
    endtask

    task automatic hostWrite(input logic [3:0] a, input logic [7:0] d);
        host_addr    = a;
        host_wr_data = d;
        host_wr_en   = 1'b1;
        tick();
        host_wr_en   = 1'b0;
        m_regs[a]    = d;
    endtask

    task automatic applyStimulus(input host_vec_t v);
        logic [7:0] d;
        hostWrite(v.addr, v.wdata);
        readReg(v.addr, d);
        checkOutput("host_readback", d, v.exp);
        checkOutput("regs_flat_slice", regs_flat[8*v.addr +: 8], v.exp);
    endtask

    task automatic i2cSelect();
        exp_q.push_back(m_regs[m_ptr]);
        m_in_addr      = 1'b1;
        slave_selected = 1'b1;
        tick();
    endtask

    task automatic i2cDeselect();
        slave_selected = 1'b0;
        tick();
        tick();
    endtask

    // Master writes one byte; optionally the host hits reg[ptr] in the same cycle
    task automatic i2cRxByte(input logic [7:0] b, input logic collide, input logic [7:0] hdata);
        logic [15:0] exp_strobe;
        logic [15:0] one16;
        one16      = 16'h0001;
        exp_strobe = (m_in_addr || collide) ? 16'h0000 : (one16 << m_ptr);
        slave_io_busy = 1'b1;
        repeat (3) tick();
        slave_io_busy  = 1'b0;
        slave_rd_valid = 1'b1;
        slave_rd_data  = b;
        if (collide) begin
            host_wr_en   = 1'b1;
            host_addr    = m_ptr;
            host_wr_data = hdata;
        end
        if (m_in_addr) begin
            m_ptr     = b[ADDR_W-1:0];
            m_in_addr = 1'b0;
            exp_q.push_back(m_regs[m_ptr]);
        end else begin
            m_regs[m_ptr] = collide ? hdata : b;
            m_ptr++;
        end
        tick();
        slave_rd_valid = 1'b0;
        host_wr_en     = 1'b0;
`ifdef I2C_REG_IRQ_EN
        checkOutput("irq_strobe", i2c_wr_strobe, exp_strobe);
`endif
        tick();
`ifdef I2C_REG_IRQ_EN
        checkOutput("irq_strobe_clear", i2c_wr_strobe, 16'h0000);
`endif
        tick();
    endtask

    // Master reads one byte: the shift ends with no received byte
    task automatic i2cTxByte();
        slave_io_busy = 1'b1;
        repeat (3) tick();
        slave_io_busy = 1'b0;
        m_ptr++;
        m_in_addr = 1'b0;
        exp_q.push_back(m_regs[m_ptr]);
        repeat (3) tick();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        host_vec_t  vecs [4];
        logic [7:0] d;

        vecs[0] = '{addr: 4'd1,  wdata: 8'h11, exp: 8'h11};
        vecs[1] = '{addr: 4'd8,  wdata: 8'h88, exp: 8'h88};
        vecs[2] = '{addr: 4'd9,  wdata: 8'h99, exp: 8'h99};
        vecs[3] = '{addr: 4'd14, wdata: 8'hEE, exp: 8'hEE};
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_regs_flat", regs_flat, 128'h0);
        checkOutput("reset_wr_en", slave_wr_en, 1'b0);
        checkOutput("reset_wr_data", slave_wr_data, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Host port table
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        // Pointer byte then two data bytes
        $display("[TB] sequence 1: pointer 03, write AA 55");
        i2cSelect();
        i2cRxByte(8'h03, 1'b0, 8'h00);
        i2cRxByte(8'hAA, 1'b0, 8'h00);
        i2cRxByte(8'h55, 1'b0, 8'h00);
        i2cDeselect();
        readReg(4'd3, d); checkOutput("seq1_reg3", d, 8'hAA);
        readReg(4'd4, d); checkOutput("seq1_reg4", d, 8'h55);

        // Master read from the retained pointer (5), then reselect shows ptr=7
        $display("[TB] sequence 2: read 5A, C3 from retained pointer");
        hostWrite(4'd5, 8'h5A);
        hostWrite(4'd6, 8'hC3);
        hostWrite(4'd7, 8'h3C);
        i2cSelect();
        i2cTxByte();
        i2cTxByte();
        i2cDeselect();
        checkOutput("seq2_model_ptr", m_ptr, 4'd7);
        i2cSelect();
        i2cDeselect();

        // Pointer wrap and upper pointer bits ignored
        $display("[TB] sequence 3: wrap at 0F, pointer F2");
        i2cSelect();
        i2cRxByte(8'h0F, 1'b0, 8'h00);
        i2cRxByte(8'h11, 1'b0, 8'h00);
        i2cRxByte(8'h22, 1'b0, 8'h00);
        i2cDeselect();
        readReg(4'd15, d); checkOutput("seq3_reg15", d, 8'h11);
        readReg(4'd0, d);  checkOutput("seq3_reg0", d, 8'h22);
        i2cSelect();
        i2cRxByte(8'hF2, 1'b0, 8'h00);
        i2cDeselect();

        // Host/I2C collision on reg4, then a host write after preload
        $display("[TB] sequence 4: host collision on reg4");
        i2cSelect();
        i2cRxByte(8'h04, 1'b0, 8'h00);
        i2cRxByte(8'h99, 1'b1, 8'h77);
        i2cDeselect();
        readReg(4'd4, d); checkOutput("seq4_reg4_host_wins", d, 8'h77);
        i2cSelect();
        hostWrite(4'd5, 8'hEE);
        i2cTxByte();
        i2cDeselect();
        readReg(4'd5, d); checkOutput("seq4_reg5", d, 8'hEE);

        // I2C write to reg2 (strobe 16'h0004 when the feature is built in)
        $display("[TB] sequence 6: I2C write to reg2");
        i2cSelect();
        i2cRxByte(8'h02, 1'b0, 8'h00);
        i2cRxByte(8'h5C, 1'b0, 8'h00);
        i2cDeselect();
        readReg(4'd2, d); checkOutput("seq6_reg2", d, 8'h5C);

        for (int i = 0; i < NUM_REGS; i++) begin
            checkOutput("model_regs", regs_flat[8*i +: 8], m_regs[i]);
        end

        // Asynchronous reset in the middle of a byte shift
        $display("[TB] sequence 5: async reset mid-DATA");
        i2cSelect();
        i2cRxByte(8'h01, 1'b0, 8'h00);
        slave_io_busy = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_regs", regs_flat, 128'h0);
        checkOutput("async_reset_wr_en", slave_wr_en, 1'b0);
        checkOutput("async_reset_wr_data", slave_wr_data, 8'h00);
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_ptr          = '0;
        m_in_addr      = 1'b0;
        slave_io_busy  = 1'b0;
        slave_selected = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        hostWrite(4'd0, 8'h42);
        hostWrite(4'd1, 8'h24);
        i2cSelect();
        i2cDeselect();

        repeat (3) tick();
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
